// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================
// apb_pkg: shared APB state encoding and default bus widths
// Rev 1.0
// ============================================================
package apb_pkg;

   localparam int APB_ADDR_W = 8;
   localparam int APB_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

endpackage
`default_nettype wire

// File: rtl/apb_master_bridge_if.sv
`default_nettype none
// ============================================================
// apb_master_bridge_if: command/response and APB3 signal bundle
// Rev 1.0
// ============================================================
interface apb_master_bridge_if
   import apb_pkg::*;
#(
   parameter int ADDR_W = APB_ADDR_W,
   parameter int DATA_W = APB_DATA_W
) ();

   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;

   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic              rsp_timeout;

   logic              psel;
   logic              penable;
   logic              pwrite;
   logic [ADDR_W-1:0] paddr;
   logic [DATA_W-1:0] pwdata;
   logic              pready;
   logic              pslverr;
   logic [DATA_W-1:0] prdata;

   // master: the bridge itself; slave: the command source plus APB peripheral
   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
      input  pready, pslverr, prdata,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
      output psel, penable, pwrite, paddr, pwdata
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
      output pready, pslverr, prdata,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
      input  psel, penable, pwrite, paddr, pwdata
   );

endinterface
`default_nettype wire

// File: rtl/apb_timeout_cnt.sv
`default_nettype none
// ============================================================
// apb_timeout_cnt: ACCESS wait-state counter, flags TIMEOUT-1
// Rev 1.0
// ============================================================
module apb_timeout_cnt #(
   parameter int TIMEOUT = 16
) (
   input  logic pclk,
   input  logic presetn,
   input  logic clr,
   input  logic inc,
   output logic expired
);

   localparam int              CNT_W = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = (cnt_q == LAST);

endmodule
`default_nettype wire

// File: rtl/apb_master_bridge.sv
`default_nettype none
// ============================================================
// apb_master_bridge: single-outstanding command-to-APB3 master
// Rev 1.0
// ============================================================
module apb_master_bridge
   import apb_pkg::*;
#(
   parameter int ADDR_W  = APB_ADDR_W,
   parameter int DATA_W  = APB_DATA_W,
   parameter int TIMEOUT = 16
) (
   input  logic                pclk,
   input  logic                presetn,
   apb_master_bridge_if.master bus
);

   apb_state_e        state_q, state_d;
   logic              psel_q, psel_d;
   logic              penable_q, penable_d;
   logic              pwrite_q, pwrite_d;
   logic [ADDR_W-1:0] paddr_q, paddr_d;
   logic [DATA_W-1:0] pwdata_q, pwdata_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic              rsp_err_q, rsp_err_d;
   logic              rsp_timeout_q, rsp_timeout_d;

   logic              cnt_clr;
   logic              cnt_inc;
   logic              cnt_expired;

   apb_timeout_cnt #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout_cnt (
      .pclk    (pclk),
      .presetn (presetn),
      .clr     (cnt_clr),
      .inc     (cnt_inc),
      .expired (cnt_expired)
   );

   always_comb begin
      state_d       = state_q;
      psel_d        = psel_q;
      penable_d     = penable_q;
      pwrite_d      = pwrite_q;
      paddr_d       = paddr_q;
      pwdata_d      = pwdata_q;
      rsp_valid_d   = 1'b0;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_err_d     = rsp_err_q;
      rsp_timeout_d = rsp_timeout_q;
      cnt_clr       = 1'b0;
      cnt_inc       = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.cmd_valid) begin
               state_d  = SETUP;
               psel_d   = 1'b1;
               pwrite_d = bus.cmd_write;
               paddr_d  = bus.cmd_addr;
               pwdata_d = bus.cmd_wdata;
            end
         end
         SETUP: begin
            state_d   = ACCESS;
            penable_d = 1'b1;
            cnt_clr   = 1'b1;
         end
         ACCESS: begin
            // completion is checked first so pready in the last allowed cycle beats the abort
            if (bus.pready) begin
               state_d       = IDLE;
               psel_d        = 1'b0;
               penable_d     = 1'b0;
               rsp_valid_d   = 1'b1;
               rsp_rdata_d   = pwrite_q ? '0 : bus.prdata;
               rsp_err_d     = bus.pslverr;
               rsp_timeout_d = 1'b0;
            end else if (cnt_expired) begin
               state_d       = IDLE;
               psel_d        = 1'b0;
               penable_d     = 1'b0;
               rsp_valid_d   = 1'b1;
               rsp_rdata_d   = '0;
               rsp_err_d     = 1'b1;
               rsp_timeout_d = 1'b1;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         default: begin
            state_d   = IDLE;
            psel_d    = 1'b0;
            penable_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state_q       <= IDLE;
         psel_q        <= 1'b0;
         penable_q     <= 1'b0;
         pwrite_q      <= 1'b0;
         paddr_q       <= '0;
         pwdata_q      <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_err_q     <= 1'b0;
         rsp_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         psel_q        <= psel_d;
         penable_q     <= penable_d;
         pwrite_q      <= pwrite_d;
         paddr_q       <= paddr_d;
         pwdata_q      <= pwdata_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_err_q     <= rsp_err_d;
         rsp_timeout_q <= rsp_timeout_d;
      end
   end

   assign bus.cmd_ready   = (state_q == IDLE);
   assign bus.psel        = psel_q;
   assign bus.penable     = penable_q;
   assign bus.pwrite      = pwrite_q;
   assign bus.paddr       = paddr_q;
   assign bus.pwdata      = pwdata_q;
   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.rsp_rdata   = rsp_rdata_q;
   assign bus.rsp_err     = rsp_err_q;
   assign bus.rsp_timeout = rsp_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
`default_nettype none
// ============================================================
// tb_apb_master_bridge: scoreboard bench with 8-register APB peripheral model
// Rev 1.0
// ============================================================
module tb_apb_master_bridge;
   import apb_pkg::*;

   localparam int TIMEOUT = 16;

   logic pclk    = 1'b0;
   logic presetn = 1'b0;
   always #5 pclk = ~pclk;

   apb_master_bridge_if #(.ADDR_W(8), .DATA_W(8)) bif ();

   apb_master_bridge #(
      .ADDR_W  (8),
      .DATA_W  (8),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .pclk    (pclk),
      .presetn (presetn),
      .bus     (bif)
   );

   typedef struct {
      logic [7:0] rdata;
      logic       err;
      logic       tmo;
      int         cyc;
   } exp_t;

   exp_t       sb[$];
   exp_t       mon_e;
   int         errors   = 0;
   int         checks   = 0;
   int         cyc      = 0;
   int         acc_cnt;
   int         wait_cfg = 0;
   int         psel_cnt = 0;
   int         pen_cnt  = 0;
   logic [7:0] exp_paddr   = 8'h00;
   logic       exp_pwrite  = 1'b0;
   logic [7:0] exp_pwdata  = 8'h00;
   logic [7:0] mem [8];

   always @(posedge pclk) cyc <= cyc + 1;

   // Peripheral: pready after wait_cfg wait states; addresses above 7 error out
   always @(posedge pclk or negedge presetn) begin
      if (!presetn)
         acc_cnt <= 0;
      else if (bif.psel && bif.penable && !bif.pready)
         acc_cnt <= acc_cnt + 1;
      else
         acc_cnt <= 0;
   end

   assign bif.pready  = bif.psel && bif.penable && (acc_cnt == wait_cfg);
   assign bif.pslverr = bif.pready && (bif.paddr > 8'd7);
   assign bif.prdata  = !bif.pready ? 8'hEE : (bif.paddr > 8'd7) ? 8'h00 : mem[bif.paddr[2:0]];

   always @(posedge pclk) begin
      if (!presetn) begin
         for (int i = 0; i < 8; i++) mem[i] <= 8'h00;
      end else if (bif.pready && bif.pwrite && !bif.pslverr) begin
         mem[bif.paddr[2:0]] <= bif.pwdata;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: bus stability while selected, scoreboard pop on every response
   always @(negedge pclk) begin
      if (presetn) begin
         if (bif.psel) begin
            psel_cnt++;
            if (bif.penable) pen_cnt++;
            chk("paddr_stable", 32'(bif.paddr), 32'(exp_paddr));
            chk("pwrite_stable", 32'(bif.pwrite), 32'(exp_pwrite));
            if (exp_pwrite) chk("pwdata_stable", 32'(bif.pwdata), 32'(exp_pwdata));
         end
         if (bif.rsp_valid) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response (cycle %0d)", cyc);
            end else begin
               mon_e = sb.pop_front();
               chk("rsp_rdata", 32'(bif.rsp_rdata), 32'(mon_e.rdata));
               chk("rsp_err", 32'(bif.rsp_err), 32'(mon_e.err));
               chk("rsp_timeout", 32'(bif.rsp_timeout), 32'(mon_e.tmo));
               chk("rsp_cycle", 32'(cyc), 32'(mon_e.cyc));
               chk("psel_at_rsp", 32'(bif.psel), 32'd0);
               chk("cmd_ready_at_rsp", 32'(bif.cmd_ready), 32'd1);
            end
         end
      end
   end

   // Called at a negedge; with hold=1, cmd_valid stays high and cmd_* is scrambled while busy
   task automatic issue(input logic wr, input logic [7:0] a, input logic [7:0] d, input int waits,
                        input logic [7:0] erd, input logic eerr, input logic etmo,
                        input logic hold, output int acc);
      exp_t e;
      bit   ok = 1'b0;
      acc = -1;
      for (int i = 0; i < 200; i++) begin
         if (bif.cmd_ready) begin
            bif.cmd_write = wr;
            bif.cmd_addr  = a;
            bif.cmd_wdata = d;
            bif.cmd_valid = 1'b1;
            ok = 1'b1;
            break;
         end else begin
            bif.cmd_write = 1'($urandom);
            bif.cmd_addr  = 8'($urandom);
            bif.cmd_wdata = 8'($urandom);
         end
         @(negedge pclk);
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL accept_timeout: got cmd_ready=0 expected 1 within 200 cycles");
         bif.cmd_valid = 1'b0;
         return;
      end
      acc        = cyc + 1;
      wait_cfg   = waits;
      exp_paddr  = a;
      exp_pwrite = wr;
      exp_pwdata = d;
      e.rdata = erd;
      e.err   = eerr;
      e.tmo   = etmo;
      e.cyc   = etmo ? acc + 1 + TIMEOUT : acc + 2 + waits;
      sb.push_back(e);
      @(negedge pclk);
      if (!hold) bif.cmd_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge pclk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL rsp_missing: got %0d pending responses expected 0", sb.size());
         sb.delete();
      end
      @(negedge pclk);
   endtask

   initial begin
      int n1, n2, n3, n4, p0, e0;
      bif.cmd_valid = 1'b0;
      bif.cmd_write = 1'b0;
      bif.cmd_addr  = 8'h00;
      bif.cmd_wdata = 8'h00;
      repeat (3) @(negedge pclk);

      chk("rst_psel", 32'(bif.psel), 32'd0);
      chk("rst_penable", 32'(bif.penable), 32'd0);
      chk("rst_pwrite", 32'(bif.pwrite), 32'd0);
      chk("rst_paddr", 32'(bif.paddr), 32'd0);
      chk("rst_pwdata", 32'(bif.pwdata), 32'd0);
      chk("rst_rsp_valid", 32'(bif.rsp_valid), 32'd0);
      chk("rst_rsp_rdata", 32'(bif.rsp_rdata), 32'd0);
      chk("rst_rsp_err", 32'(bif.rsp_err), 32'd0);
      chk("rst_rsp_timeout", 32'(bif.rsp_timeout), 32'd0);
      chk("rst_cmd_ready", 32'(bif.cmd_ready), 32'd1);
      presetn = 1'b1;
      @(negedge pclk);

      // write with two wait states, then read it back
      p0 = psel_cnt;
      e0 = pen_cnt;
      issue(1'b1, 8'h02, 8'hA5, 2, 8'h00, 1'b0, 1'b0, 1'b0, n1);
      drain();
      chk("psel_cycles", 32'(psel_cnt - p0), 32'd4);
      chk("penable_cycles", 32'(pen_cnt - e0), 32'd3);
      issue(1'b0, 8'h02, 8'h00, 0, 8'hA5, 1'b0, 1'b0, 1'b0, n1);
      drain();

      issue(1'b0, 8'h09, 8'h00, 1, 8'h00, 1'b1, 1'b0, 1'b0, n1);
      drain();

      issue(1'b0, 8'h05, 8'h00, 1000, 8'h00, 1'b1, 1'b1, 1'b0, n1);
      drain();

      // completion in the last ACCESS cycle before abort, then one short of it
      issue(1'b0, 8'h02, 8'h00, TIMEOUT - 1, 8'hA5, 1'b0, 1'b0, 1'b0, n1);
      drain();
      issue(1'b1, 8'h07, 8'h3C, TIMEOUT - 2, 8'h00, 1'b0, 1'b0, 1'b0, n1);
      drain();

      // cmd_valid held high with scrambled fields while busy
      issue(1'b1, 8'h01, 8'h11, 0, 8'h00, 1'b0, 1'b0, 1'b1, n1);
      issue(1'b1, 8'h03, 8'h33, 0, 8'h00, 1'b0, 1'b0, 1'b1, n2);
      chk("accept_spacing_1", 32'(n2 - n1), 32'd3);
      issue(1'b0, 8'h01, 8'h00, 0, 8'h11, 1'b0, 1'b0, 1'b1, n3);
      chk("accept_spacing_2", 32'(n3 - n2), 32'd3);
      issue(1'b0, 8'h07, 8'h00, 0, 8'h3C, 1'b0, 1'b0, 1'b0, n4);
      chk("accept_spacing_3", 32'(n4 - n3), 32'd3);
      drain();

      // reset in the middle of a hung ACCESS
      issue(1'b0, 8'h04, 8'h00, 1000, 8'h00, 1'b1, 1'b1, 1'b0, n1);
      repeat (3) @(negedge pclk);
      chk("pre_rst_penable", 32'(bif.penable), 32'd1);
      #2 presetn = 1'b0;
      #1;
      chk("midrst_psel", 32'(bif.psel), 32'd0);
      chk("midrst_penable", 32'(bif.penable), 32'd0);
      chk("midrst_rsp_valid", 32'(bif.rsp_valid), 32'd0);
      chk("midrst_cmd_ready", 32'(bif.cmd_ready), 32'd1);
      chk("midrst_paddr", 32'(bif.paddr), 32'd0);
      sb.delete();
      @(negedge pclk);
      presetn = 1'b1;
      repeat (20) @(negedge pclk);

      issue(1'b1, 8'h06, 8'h5A, 1, 8'h00, 1'b0, 1'b0, 1'b0, n1);
      drain();
      issue(1'b0, 8'h06, 8'h00, 3, 8'h5A, 1'b0, 1'b0, 1'b0, n1);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200000 time units");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
